scr1_tb_imem_responder: RTL and testbench

SCR1_TB_IMEM_RESPONDER -- requirements
Module: scr1_tb_imem_responder

---
 rtl/scr1_tb_imem_pkg.sv | 17 +
 rtl/scr1_tb_imem_queue.sv | 49 ++++
 rtl/scr1_tb_imem_responder.sv | 54 +++++
 tb/tb_scr1_tb_imem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/scr1_tb_imem_pkg.sv
// scr1_tb_imem_pkg: shared response/command encodings and parameter defaults
// for the instruction-memory responder.
package scr1_tb_imem_pkg;
  localparam int MEM_WORDS_DEF = 1024;
  localparam int RESP_LAT_DEF = 2;
  localparam int QDEPTH_DEF = 4;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_RDY  = 2'b01,
    RESP_ER   = 2'b10
  } imem_resp_e;
  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } imem_cmd_e;
endpackage

// File: rtl/scr1_tb_imem_queue.sv
// scr1_tb_imem_queue: in-order queue of accepted fetches, each entry carrying
// a saturating age; the head is reported ready once its age reaches RESP_LAT.
module scr1_tb_imem_queue
  import scr1_tb_imem_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int RESP_LAT = RESP_LAT_DEF,
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_ready,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [LAT_W-1:0] LAT = LAT_W'(RESP_LAT);
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic [W-1:0] r_data [QDEPTH];
  logic [LAT_W-1:0] r_age [QDEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  // The accept cycle itself counts as age 0, so a new entry starts at 1.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++)
      r_age[i] <= (r_age[i] == LAT) ? r_age[i] : r_age[i] + 1'b1;
    if (i_push) begin
      r_data[r_wp] <= i_data;
      r_age[r_wp] <= LAT_W'(1);
    end
  end
  assign o_head = r_data[r_rp];
  assign o_ready = r_age[r_rp] == LAT;
  assign o_full = r_cnt == (PW+1)'(QDEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/scr1_tb_imem_responder.sv
// scr1_tb_imem_responder: fixed-latency in-order instruction memory model with
// bench preload port; SCR1_TB_IMEM_ERR_INJ_EN adds err_addr error injection.
module scr1_tb_imem_responder
  import scr1_tb_imem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int RESP_LAT = RESP_LAT_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic        imem_cmd,
  input  logic [31:0] imem_addr,
  output logic        imem_req_ack,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
`ifdef SCR1_TB_IMEM_ERR_INJ_EN
  input  logic [31:0] err_addr,
`endif
  input  logic [31:0] ld_data
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MW = 32'(MEM_WORDS);
  logic [31:0] r_mem [MEM_WORDS];
  logic w_full, w_empty, w_ready, w_pop, w_err;
  logic [AW:0] w_head;
  always_comb begin
    w_err = (imem_cmd == CMD_WR) | ({2'b00, imem_addr[31:2]} >= MW) | (|imem_addr[1:0]);
`ifdef SCR1_TB_IMEM_ERR_INJ_EN
    w_err = w_err | (imem_addr == err_addr);
`endif
  end
  assign imem_req_ack = rst_n & imem_req & ~w_full;
  assign w_pop = w_ready & ~w_empty;
  scr1_tb_imem_queue #(.QDEPTH(QDEPTH), .RESP_LAT(RESP_LAT), .W(AW + 1)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (imem_req_ack),
    .i_data  ({w_err, imem_addr[AW+1:2]}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_ready (w_ready),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // Read in the response cycle; a same-cycle preload lands after, so old data wins.
  assign imem_resp = w_pop ? (w_head[AW] ? RESP_ER : RESP_RDY) : RESP_IDLE;
  assign imem_rdata = (w_pop & ~w_head[AW]) ? r_mem[w_head[AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (ld_we && ld_addr < MW) r_mem[ld_addr[AW-1:0]] <= ld_data;
endmodule

// File: tb/tb_scr1_tb_imem_responder.sv
// tb_scr1_tb_imem_responder: directed checks of the imem responder; a second
// instance with RESP_LAT=6 exercises queue-full back-pressure.
module tb_scr1_tb_imem_responder;
  import scr1_tb_imem_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req, cmd, ack, s_req, s_ack, ld_we;
  logic s_cmd = 1'b0;
  logic [31:0] addr, rdata, s_addr, s_rdata, ld_addr, ld_data, err_addr;
  logic [1:0] resp, s_resp;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  scr1_tb_imem_responder u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_cmd(cmd), .imem_addr(addr),
    .imem_req_ack(ack), .imem_rdata(rdata), .imem_resp(resp),
    .ld_we(ld_we), .ld_addr(ld_addr),
`ifdef SCR1_TB_IMEM_ERR_INJ_EN
    .err_addr(err_addr),
`endif
    .ld_data(ld_data)
  );
  scr1_tb_imem_responder #(.RESP_LAT(6), .QDEPTH(4)) u_dut_slow (
    .clk(clk), .rst_n(rst_n), .imem_req(s_req), .imem_cmd(s_cmd), .imem_addr(s_addr),
    .imem_req_ack(s_ack), .imem_rdata(s_rdata), .imem_resp(s_resp),
    .ld_we(ld_we), .ld_addr(ld_addr),
`ifdef SCR1_TB_IMEM_ERR_INJ_EN
    .err_addr(err_addr),
`endif
    .ld_data(ld_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_word(input int k);
    return k == 0 ? 32'h0000_C033 : 32'(32'h1000 + k);
  endfunction
  task automatic cyc(input logic r, input logic c, input logic [31:0] a,
                     input logic [1:0] er, input logic [31:0] ed, input string tag);
    req = r;
    cmd = c;
    addr = a;
    @(negedge clk);
    chk({tag, ".ack"}, {31'b0, ack}, {31'b0, r});
    chk({tag, ".resp"}, {30'b0, resp}, {30'b0, er});
    chk({tag, ".rdata"}, rdata, ed);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    int rc [8] = '{6, 7, 8, 9, 13, 14, 15, 16};
    logic [1:0] er;
    logic [31:0] ed;
    req = 1'b1; cmd = 1'b0; addr = '0;
    s_req = 1'b1; s_addr = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0; err_addr = 32'h8;
    @(negedge clk);
    chk("rst.ack", {31'b0, ack}, 32'd0);
    chk("rst.s_ack", {31'b0, s_ack}, 32'd0);
    chk("rst.resp", {30'b0, resp}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = 1'b0; s_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_we = 1'b1; ld_addr = i; ld_data = exp_word(i);
      @(posedge clk);
      #1;
    end
    ld_we = 1'b0;
    // single read, two-cycle latency
    cyc(1, 0, 32'h0, RESP_IDLE, 0, "r37.c0");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r37.c1");
    cyc(0, 0, 32'h0, RESP_RDY, 32'h0000_C033, "r37.c2");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r37.c3");
    // back-to-back reads at default latency never fill the queue
    for (int c = 0; c < 10; c++)
      cyc(c < 8, 0, 32'(4 * c), c >= 2 ? RESP_RDY : RESP_IDLE,
          c >= 2 ? exp_word(c - 2) : 32'h0, $sformatf("r38.c%0d", c));
    // RESP_LAT=6: ack drops while 4 are outstanding, including the first pop cycle
    k = 0;
    for (int c = 0; c < 18; c++) begin
      s_req = k < 8;
      s_addr = 32'(4 * k);
      @(negedge clk);
      er = RESP_IDLE;
      ed = '0;
      for (int j = 0; j < 8; j++)
        if (rc[j] == c) begin
          er = RESP_RDY;
          ed = exp_word(j);
        end
      chk($sformatf("full.c%0d.ack", c), {31'b0, s_ack}, {31'b0, c < 4 || (c >= 7 && c <= 10)});
      chk($sformatf("full.c%0d.resp", c), {30'b0, s_resp}, {30'b0, er});
      chk($sformatf("full.c%0d.rdata", c), s_rdata, ed);
      if (s_ack) k++;
      @(posedge clk);
      #1;
    end
    s_req = 1'b0;
    chk("full.accepts", k, 8);
    // write command, misaligned and out-of-range reads error out
    cyc(1, 1, 32'h10, RESP_IDLE, 0, "r39.wr");
    cyc(1, 0, 32'h3, RESP_IDLE, 0, "r39.mis");
    cyc(1, 0, 32'h4, RESP_ER, 0, "r39.al");
    cyc(1, 0, 32'h1000, RESP_ER, 0, "r39.oor");
    cyc(0, 0, 32'h0, RESP_RDY, exp_word(1), "r39.c4");
    cyc(0, 0, 32'h0, RESP_ER, 0, "r39.c5");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r39.c6");
    // read-before-write on a same-cycle preload
    ld_we = 1'b1; ld_addr = 32'd5; ld_data = 32'h11;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
    cyc(1, 0, 32'h14, RESP_IDLE, 0, "r40.rd");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r40.c1");
    ld_we = 1'b1; ld_data = 32'h22;
    cyc(0, 0, 32'h0, RESP_RDY, 32'h11, "r40.old");
    ld_we = 1'b0;
    cyc(1, 0, 32'h14, RESP_IDLE, 0, "r40.rerd");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r40.c4");
    cyc(0, 0, 32'h0, RESP_RDY, 32'h22, "r40.new");
    // out-of-range preload must not alias onto word 0
    ld_we = 1'b1; ld_addr = 32'd1024; ld_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
    cyc(1, 0, 32'h0, RESP_IDLE, 0, "r29.rd");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r29.c1");
    cyc(0, 0, 32'h0, RESP_RDY, 32'h0000_C033, "r29.c2");
    // reset with 3 outstanding on the slow instance
    s_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_addr = 32'(4 * c);
      @(posedge clk);
      #1;
    end
    req = 1'b1; addr = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("r41.rst.ack", {31'b0, ack}, 32'd0);
    chk("r41.rst.s_ack", {31'b0, s_ack}, 32'd0);
    chk("r41.rst.s_resp", {30'b0, s_resp}, 32'd0);
    chk("r41.rst.s_rdata", s_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = 1'b0; s_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("r41.post%0d.s_resp", c), {30'b0, s_resp}, 32'd0);
      chk($sformatf("r41.post%0d.resp", c), {30'b0, resp}, 32'd0);
      @(posedge clk);
      #1;
    end
    cyc(1, 0, 32'h0, RESP_IDLE, 0, "r41.new.c0");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r41.new.c1");
    cyc(0, 0, 32'h0, RESP_RDY, 32'h0000_C033, "r41.new.c2");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "r41.new.c3");
    // err_addr = 0x8 only matters when error injection is built in
    cyc(1, 0, 32'h4, RESP_IDLE, 0, "inj.c0");
    cyc(1, 0, 32'h8, RESP_IDLE, 0, "inj.c1");
    cyc(1, 0, 32'hC, RESP_RDY, exp_word(1), "inj.c2");
`ifdef SCR1_TB_IMEM_ERR_INJ_EN
    cyc(0, 0, 32'h0, RESP_ER, 0, "inj.c3");
`else
    cyc(0, 0, 32'h0, RESP_RDY, exp_word(2), "inj.c3");
`endif
    cyc(0, 0, 32'h0, RESP_RDY, exp_word(3), "inj.c4");
    cyc(0, 0, 32'h0, RESP_IDLE, 0, "inj.c5");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
